// File: rtl/fpu_f64_pkg.sv
// Shared types for the f64 op scheduler: op codes, FSM states and the op-to-unit-func map.
package fpu_f64_pkg;

  typedef enum logic [2:0] {
    OP_GT  = 3'd0,
    OP_GE  = 3'd1,
    OP_LT  = 3'd2,
    OP_LE  = 3'd3,
    OP_F2I = 3'd4,
    OP_I2F = 3'd5,
    OP_U2F = 3'd6,
    OP_INV = 3'd7
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam logic [1:0] CVT_FUNC_NONE = 2'd0;
  localparam logic [1:0] CVT_FUNC_F2I  = 2'd1;
  localparam logic [1:0] CVT_FUNC_I2F  = 2'd2;
  localparam logic [1:0] CVT_FUNC_U2F  = 2'd3;

  function automatic logic is_cvt_op(input fpu_op_e op);
    return (op == OP_F2I) || (op == OP_I2F) || (op == OP_U2F);
  endfunction

  function automatic logic [1:0] cvt_func_of(input fpu_op_e op);
    case (op)
      OP_F2I:  return CVT_FUNC_F2I;
      OP_I2F:  return CVT_FUNC_I2F;
      OP_U2F:  return CVT_FUNC_U2F;
      default: return CVT_FUNC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/fpu_f64_op_scheduler_arb.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is issued.
module fpu_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // prio_q = 0 favours req0, 1 favours req1
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt0 = en & req0 & (~req1 | ~prio_q);
    gnt1 = en & req1 & (~req0 | prio_q);
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt0) prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/fpu_f64_op_scheduler.sv
// Schedules ops from two requesters onto a compare unit and a convert unit, one at a time.
// Optional WAIT-state abort is enabled by defining FPU_SCHED_TIMEOUT_EN.
module fpu_f64_op_scheduler
  import fpu_f64_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clean,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [63:0] req0_numA,
  input  logic [63:0] req0_numB,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [63:0] req1_numA,
  input  logic [63:0] req1_numB,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic        cmp_start,
  output logic [63:0] cmp_numA,
  output logic [63:0] cmp_numB,
  output logic [1:0]  cmp_func,
  input  logic [63:0] cmp_numC,
  input  logic        cmp_ready,
  output logic        cvt_start,
  output logic [63:0] cvt_numA,
  output logic [63:0] cvt_numB,
  output logic [1:0]  cvt_func,
  input  logic [63:0] cvt_numC,
  input  logic        cvt_ready,
  input  logic        cvt_err
);

  sched_state_e state_q, state_d;
  fpu_op_e      op_q, op_d;
  logic [63:0]  num_a_q, num_a_d;
  logic [63:0]  num_b_q, num_b_d;
  logic         id_q, id_d;
  logic [63:0]  rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  logic arb_en, gnt0, gnt1, accept;
  logic op_is_cvt, op_is_inv, sel_ready, busy, capture, timeout_hit;

  // Accepts are only offered in IDLE and never in a flush or reset cycle
  assign arb_en = (state_q == ST_IDLE) && !clean && !rst;

  fpu_rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign accept    = gnt0 | gnt1;
  assign op_is_cvt = is_cvt_op(op_q);
  assign op_is_inv = (op_q == OP_INV);
  assign sel_ready = op_is_cvt ? cvt_ready : cmp_ready;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign capture   = busy && !op_is_inv && sel_ready && !clean;

`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = '0;
    if (state_q == ST_WAIT) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end

  assign timeout_hit = (state_q == ST_WAIT) && !sel_ready &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (op_is_inv || sel_ready) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (sel_ready || timeout_hit) state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (clean) state_d = ST_IDLE;
  end

  always_comb begin
    rsp_valid = (state_q == ST_RESP);
    cmp_start = (state_q == ST_ISSUE) && !op_is_cvt && !op_is_inv && !clean && !rst;
    cvt_start = (state_q == ST_ISSUE) && op_is_cvt && !clean && !rst;
  end

  always_comb begin
    op_d       = op_q;
    num_a_d    = num_a_q;
    num_b_d    = num_b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d    = gnt1 ? fpu_op_e'(req1_op) : fpu_op_e'(req0_op);
      num_a_d = gnt1 ? req1_numA : req0_numA;
      num_b_d = gnt1 ? req1_numB : req0_numB;
      id_d    = gnt1;
    end
    if (capture) begin
      rsp_data_d = op_is_cvt ? cvt_numC : cmp_numC;
      rsp_err_d  = op_is_cvt & cvt_err;
    end else if (!clean && ((state_q == ST_ISSUE && op_is_inv) || timeout_hit)) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_GT;
      num_a_q    <= '0;
      num_b_q    <= '0;
      id_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      num_a_q    <= num_a_d;
      num_b_q    <= num_b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_id     = id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign cmp_numA   = num_a_q;
  assign cmp_numB   = num_b_q;
  assign cmp_func   = op_q[1:0];
  assign cvt_numA   = num_a_q;
  assign cvt_numB   = num_b_q;
  assign cvt_func   = cvt_func_of(op_q);

endmodule

// File: doc/fpu_f64_op_scheduler.md
FPU_F64_OP_SCHEDULER -- requirements
Module: fpu_f64_op_scheduler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 16, the WAIT-state cycle limit (active only with FPU_SCHED_TIMEOUT_EN).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Port clk, input, 1, the system clock.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port clean, input, 1: synchronous pipeline flush.
REQ-005 Ports reqN_valid, input, 1 (N=0,1): requester N presents an op.
REQ-006 Ports reqN_ready, output, 1 (N=0,1): op accepted this cycle.
REQ-007 Ports reqN_op, input, 3 (N=0,1): 0 GT, 1 GE, 2 LT, 3 LE, 4 F64->INT64, 5 INT64->F64, 6 UINT64->F64, 7 invalid.
REQ-008 Ports reqN_numA and reqN_numB, input, 64 each (N=0,1): operands.
REQ-009 Port rsp_valid, output, 1: response held.
REQ-010 Port rsp_ready, input, 1: consumer accepts the response.
REQ-011 Ports rsp_id, output, 1; rsp_data, output, 64; rsp_err, output, 1: requester index, result, error flag.
REQ-012 Ports cmp_start, output, 1; cmp_numA and cmp_numB, output, 64; cmp_func, output, 2; cmp_numC, input, 64; cmp_ready, input, 1: compare-unit side.
REQ-013 Ports cvt_start, output, 1; cvt_numA and cvt_numB, output, 64; cvt_func, output, 2; cvt_numC, input, 64; cvt_ready, input, 1; cvt_err, input, 1: convert-unit side.

Function
REQ-014 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-015 Requester handshakes SHALL occur only in IDLE, with at most one reqN_ready high per cycle.
REQ-016 Arbitration SHALL be round-robin: if both requesters are valid, the one not granted last wins; a single valid requester always wins.
REQ-017 An accept SHALL register op, numA, numB and the winner id, and move the FSM IDLE->ISSUE.
REQ-018 In ISSUE, the FSM SHALL pulse the selected unit's start for exactly one cycle, with func = op[1:0] for the compare unit and {op 4->1, 5->2, 6->3} for the convert unit.
REQ-019 Unit operand and func outputs SHALL remain stable from ISSUE until result capture; the unselected unit's start SHALL stay 0.
REQ-020 The result SHALL be captured in the first cycle, ISSUE or WAIT, in which the selected unit's ready is 1; the FSM then moves to RESP, otherwise ISSUE->WAIT.
REQ-021 With single-cycle units, accept at cycle N SHALL give rsp_valid=1 at cycle N+2.
REQ-022 Op 7 SHALL start no unit and SHALL go ISSUE->RESP with rsp_data=0 and rsp_err=1.
REQ-023 rsp_err SHALL equal cvt_err captured with the result for convert ops, and 0 for compare ops.
REQ-024 RESP SHALL hold rsp_* stable while rsp_ready=0; rsp_valid and rsp_ready both high SHALL return the FSM to IDLE, and a new accept is allowed from the next cycle.
REQ-025 clean SHALL force IDLE, rsp_valid=0, both starts 0 and discard any in-flight result; the round-robin pointer SHALL be kept.
REQ-026 clean SHALL take priority over accept and capture in the same cycle.

Reset
REQ-027 rst SHALL set state IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, reqN_ready=0, starts=0, unit operand outputs=0, and the round-robin pointer to favour req0; rst SHALL override clean.

Configuration
REQ-028 With FPU_SCHED_TIMEOUT_EN defined, a WAIT counter SHALL abort the op after TIMEOUT_CYC cycles without ready and enter RESP with rsp_data=0 and rsp_err=1.
REQ-029 Without FPU_SCHED_TIMEOUT_EN, WAIT SHALL persist until ready, rst or clean, and no counter SHALL be synthesised.

Structure
REQ-030 Package fpu_f64_pkg SHALL hold the op enum, the FSM state enum and the op-to-func mapping constants.
REQ-031 Sub-module fpu_rr_arb2 SHALL implement the 2-way round-robin grant and its pointer.

Verification
REQ-032 Directed scenario: req0 op0, numA=0x4000000000000000, numB=0x3FF0000000000000, cmp_numC=1 -> rsp_valid at N+2, rsp_data=1, rsp_id=0, rsp_err=0.
REQ-033 Directed scenario: req0 and req1 valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 and no requester starves.
REQ-034 Directed scenario: op7 on req1 -> no start pulse, rsp_data=0, rsp_err=1, rsp_id=1.
REQ-035 Directed scenario: rsp_ready=0 for 5 cycles -> rsp_* stable, reqN_ready=0 throughout, single accept after release.
REQ-036 Directed scenario: cvt_ready held 0, clean asserted in WAIT -> FSM IDLE next cycle with no response; with the macro and no clean, err response after 16 cycles.
REQ-037 Directed scenario: rst asserted in RESP together with clean -> every output reaches its reset value and the next grant goes to req0.
